// File: rtl/atm_pin_entry.sv
// ATM PIN entry: collects four BCD digits, compares them with stored_pin on enter and reports only the match result.
// Optional inactivity timeout is compiled in when PIN_TIMEOUT_EN is defined.
module atm_pin_entry #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        card_inserted,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [15:0] stored_pin,
    output logic        pin_entered,
    output logic        pin_correct,
    output logic [2:0]  digit_count,
    output logic        entry_timeout,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

    state_t      state_q, state_d;
    logic [15:0] buffer_q, buffer_d;
    logic [2:0]  count_q, count_d;
    logic        pin_entered_q, pin_entered_d;
    logic        pin_correct_q, pin_correct_d;
    logic        entry_timeout_q, entry_timeout_d;
    logic        busy_q, busy_d;

    logic [3:0]  digit_match;
    logic        pin_match;
    logic        key_accept;
    logic        is_digit;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit_cmp
            assign digit_match[gi] = (buffer_q[gi*4 +: 4] == stored_pin[gi*4 +: 4]);
        end
    endgenerate

    assign pin_match  = &digit_match;
    // Reserved codes D-F are not accepted keys: they neither act nor restart the timer.
    assign key_accept = key_valid && (key_code <= 4'hC);
    assign is_digit   = (key_code <= 4'd9);

`ifdef PIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    always_comb begin
        state_d         = state_q;
        buffer_d        = buffer_q;
        count_d         = count_q;
        pin_entered_d   = 1'b0;
        pin_correct_d   = 1'b0;
        entry_timeout_d = 1'b0;
`ifdef PIN_TIMEOUT_EN
        timer_d         = '0;
`endif
        case (state_q)
            IDLE: begin
                if (card_inserted) begin
                    state_d  = COLLECT;
                    buffer_d = '0;
                    count_d  = '0;
                end
            end
            COLLECT: begin
                if (key_accept) begin
                    if (is_digit) begin
                        if (count_q < 3'd4) begin
                            buffer_d = {buffer_q[11:0], key_code};
                            count_d  = count_q + 3'd1;
                        end
                    end else if (key_code == 4'hA || key_code == 4'hC) begin
                        buffer_d = '0;
                        count_d  = '0;
                    end else if (count_q == 3'd4) begin
                        state_d       = REPORT;
                        pin_entered_d = 1'b1;
                        pin_correct_d = pin_match;
                    end
                end else begin
`ifdef PIN_TIMEOUT_EN
                    if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        entry_timeout_d = 1'b1;
                        buffer_d        = '0;
                        count_d         = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
`endif
                end
            end
            REPORT: begin
                state_d  = COLLECT;
                buffer_d = '0;
                count_d  = '0;
            end
            default: begin
                state_d  = IDLE;
                buffer_d = '0;
                count_d  = '0;
            end
        endcase

        // Card removal overrides everything, including a same-cycle enter key.
        if (!card_inserted) begin
            state_d         = IDLE;
            buffer_d        = '0;
            count_d         = '0;
            pin_entered_d   = 1'b0;
            pin_correct_d   = 1'b0;
            entry_timeout_d = 1'b0;
`ifdef PIN_TIMEOUT_EN
            timer_d         = '0;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            buffer_q        <= '0;
            count_q         <= '0;
            pin_entered_q   <= 1'b0;
            pin_correct_q   <= 1'b0;
            entry_timeout_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            buffer_q        <= buffer_d;
            count_q         <= count_d;
            pin_entered_q   <= pin_entered_d;
            pin_correct_q   <= pin_correct_d;
            entry_timeout_q <= entry_timeout_d;
            busy_q          <= busy_d;
        end
    end

`ifdef PIN_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign pin_entered   = pin_entered_q;
    assign pin_correct   = pin_correct_q;
    assign digit_count   = count_q;
    assign entry_timeout = entry_timeout_q;
    assign busy          = busy_q;
endmodule
